fb_writer: RTL and testbench
============================

// Module: fb_writer
// PURPOSE
//  Wishbone write master that fills the SDRAM framebuffer read by the VGA display path.
//  - Accepts a 32-bit pixel stream (valid/ready, start-of-frame flag).
//  - Writes each pixel to BASE_ADDR + (x + y*HDISP)*4, raster order, one classic single write per pixel.
//  - Sits on the wshb_if bus next to the display reader, in the SDRAM clock domain.
// PARAMETERS
//  HDISP      800    active pixels per line
//  VDISP      480    active lines per frame
//  BASE_ADDR  32'h0  byte address of pixel (0,0); must be 4-byte aligned
// PORTS
//  wshb_ifm.clk  in   1   sole clock; all logic on its rising edge
//  wshb_ifm.rst  in   1   synchronous, active-high reset
//  wshb_ifm      mst  -   wshb_if.master: adr,dat_ms,we,sel,stb,cyc,cti,bte out; ack,dat_sm in
//  pix_valid     in   1   pix_data/pix_sof valid
//  pix_ready     out  1   block accepts the pixel this cycle (transfer = valid & ready)
//  pix_data      in   32  pixel, RGB in [23:0]; [31:24] written unchanged
//  pix_sof       in   1   pixel is (0,0) of a new frame
//  frame_done    out  1   one-cycle pulse when the ack for pixel (HDISP-1,VDISP-1) is received
//  sof_err       out  1   one-cycle pulse when a pix_sof arrives before the current frame completes
// BEHAVIOUR
//  Reset: state=IDLE, x=y=0, hold register=0.
//   - pix_ready=1; stb=cyc=we=0; frame_done=sof_err=0 on the first edge with rst=1.
//   - Reset mid-write abandons the transfer: stb/cyc drop at that edge and the pending ack is ignored.
//  Constant outputs: sel=4'hF, cti=3'b000, bte=2'b00, we=stb.
//  Bus outputs: cyc=stb, both decoded from state (WRITE) only.
//   - adr and dat_ms come from registers.
//   - adr, dat_ms and we stay stable while stb=1, until ack.
//  FSM:
//   - IDLE: pix_ready=1.
//     - valid & sof: capture data, x=y=0, go to WRITE.
//     - valid & !sof: pixel dropped, stay in IDLE.
//   - WRITE: stb=1, pix_ready=0; wait for ack (no timeout).
//     - On ack at the last pixel: frame_done=1 next cycle, x=y=0, go to IDLE.
//     - On any other ack: advance x, wrap at HDISP-1 to 0 and increment y, go to FETCH.
//   - FETCH: pix_ready=1.
//     - valid & !sof: capture, go to WRITE.
//     - valid & sof: sof_err=1, x=y=0, capture, go to WRITE (resync).
//     - No valid: stay in FETCH.
//  Throughput: minimum 2 cycles plus slave latency per pixel. ack without stb is ignored.
//  Address arithmetic:
//   - x is $clog2(HDISP) bits, y is $clog2(VDISP) bits.
//   - Product is computed at 32 bits, then adr = BASE_ADDR + ((y*HDISP + x) << 2).
//   - Address is registered when the pixel is captured.
// CONFIGURATION
//  FB_WRITER_PATTERN_EN defined:
//   - pix_* inputs are ignored; pix_ready is tied to 0; sof_err is never asserted.
//   - An internal generator supplies each pixel when the FSM would capture one.
//     - 24'hFFFFFF when x[3:0]==0 or y[3:0]==0.
//     - Otherwise {x[7:0], y[7:0], 8'h00}.
//   - After reset the generator frame starts immediately, with no wait for sof.
//   - The generator loops frames continuously: IDLE behaves like an sof capture.
//  Not defined: stream behaviour exactly as in BEHAVIOUR.
// STRUCTURE
//  Package fb_pkg:
//   - typedef enum logic[1:0] {IDLE, WRITE, FETCH} fb_wr_state_t
//   - localparam WSHB_SEL_ALL=4'hF, CTI_CLASSIC=3'b000, BTE_LINEAR=2'b00
//   - function fb_addr(x, y, hdisp, base) returning logic[31:0]
//  Sub-module fb_pattern_gen(x, y -> pixel):
//   - Combinational, instantiated only under FB_WRITER_PATTERN_EN.
// TESTING
//  Responder model: ack one cycle after stb. HDISP=4, VDISP=2.
//  1. Reset, then a frame of 8 pixels 0x10..0x17 with sof on the first.
//     -> writes to adr 0x00..0x1C, data 0x10..0x17.
//     -> frame_done pulses once, after the ack at adr 0x1C.
//  2. Pixels with sof=0 while in IDLE.
//     -> no stb and pix_ready stays 1; the first sof pixel then goes to adr BASE_ADDR.
//  3. Responder delays ack by 5 cycles.
//     -> stb, adr and dat_ms are held constant for all 5 cycles; pix_ready=0 throughout.
//  4. sof on the 3rd pixel of a frame.
//     -> sof_err pulses once; that pixel goes to adr 0x00; the remaining pixels continue at 0x04.
//  5. Assert rst while stb=1, then deassert.
//     -> stb=cyc=0 on the next edge; a late ack causes no counter change; the FSM is in IDLE.
//  6. FB_WRITER_PATTERN_EN defined, BASE_ADDR=32'h100.
//     -> writes start after reset with no stimulus: first write adr 0x100, data 0xFFFFFF.
//     -> frame_done repeats every 8 writes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer writer: FSM state encoding,
// fixed Wishbone attribute values and the pixel-to-byte-address helper.
package fb_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, FETCH} fb_wr_state_t;

    localparam logic [3:0] WSHB_SEL_ALL = 4'hF;
    localparam logic [2:0] CTI_CLASSIC  = 3'b000;
    localparam logic [1:0] BTE_LINEAR   = 2'b00;

    // Byte address of pixel (x, y) in a raster-ordered 32-bit-per-pixel buffer.
    function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] hdisp,
                                            input logic [31:0] base);
        return base + ((y * hdisp + x) << 2);
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the framebuffer writer and the display reader;
// carries the SDRAM-domain clock and synchronous reset alongside the bus.
interface wshb_if (input logic clk, input logic rst);

    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (input clk, rst, ack, dat_sm,
                    output adr, dat_ms, we, sel, stb, cyc, cti, bte);

    modport slave  (input clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
                    output ack, dat_sm);

endinterface

// File: rtl/fb_pattern_gen.sv
// Test-pattern source: white grid lines every 16 pixels, otherwise the pixel
// encodes its own coordinates. Used only when FB_WRITER_PATTERN_EN is defined.
module fb_pattern_gen (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [31:0] pixel
);

    always_comb begin
        if (x[3:0] == 4'd0 || y[3:0] == 4'd0) begin
            pixel = 32'h00FF_FFFF;
        end else begin
            pixel = {8'h00, x, y, 8'h00};
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Wishbone write master filling the SDRAM framebuffer, one classic single write
// per pixel. Define FB_WRITER_PATTERN_EN to replace the pixel stream by a generator.
module fb_writer
    import fb_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    wshb_if.master wshb_ifm,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    input  logic        pix_sof,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

    fb_wr_state_t  state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [31:0]   adr_q, adr_n;
    logic [31:0]   dat_q, dat_n;
    logic          frame_done_n, sof_err_n;
    logic          in_valid, in_sof;
    logic [31:0]   in_data;

`ifdef FB_WRITER_PATTERN_EN
    logic [31:0] pattern;

    fb_pattern_gen u_pattern_gen (
        .x     (8'(x)),
        .y     (8'(y)),
        .pixel (pattern)
    );

    // The generator always has a pixel; entering IDLE restarts the frame.
    assign in_valid  = 1'b1;
    assign in_sof    = (state == IDLE);
    assign in_data   = pattern;
    assign pix_ready = 1'b0;
`else
    assign in_valid  = pix_valid;
    assign in_sof    = pix_sof;
    assign in_data   = pix_data;
    assign pix_ready = (state != WRITE);
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch behind.
        state_n      = state;
        x_n          = x;
        y_n          = y;
        adr_n        = adr_q;
        dat_n        = dat_q;
        frame_done_n = 1'b0;
        sof_err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    x_n     = '0;
                    y_n     = '0;
                    adr_n   = BASE_ADDR;
                    dat_n   = in_data;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (wshb_ifm.ack) begin
                    if (x == X_LAST && y == Y_LAST) begin
                        frame_done_n = 1'b1;
                        x_n          = '0;
                        y_n          = '0;
                        state_n      = IDLE;
                    end else begin
                        if (x == X_LAST) begin
                            x_n = '0;
                            y_n = y + 1'b1;
                        end else begin
                            x_n = x + 1'b1;
                        end
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                if (in_valid) begin
                    dat_n   = in_data;
                    state_n = WRITE;
                    // A new frame start here means the previous frame was cut short.
                    if (in_sof) begin
                        sof_err_n = 1'b1;
                        x_n       = '0;
                        y_n       = '0;
                        adr_n     = BASE_ADDR;
                    end else begin
                        adr_n = fb_addr(32'(x), 32'(y), 32'(HDISP), BASE_ADDR);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wshb_ifm.clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (wshb_ifm.rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            adr_q      <= adr_n;
            dat_q      <= dat_n;
            frame_done <= frame_done_n;
            sof_err    <= sof_err_n;
        end
    end

    assign wshb_ifm.stb    = (state == WRITE);
    assign wshb_ifm.cyc    = (state == WRITE);
    assign wshb_ifm.we     = (state == WRITE);
    assign wshb_ifm.sel    = WSHB_SEL_ALL;
    assign wshb_ifm.cti    = CTI_CLASSIC;
    assign wshb_ifm.bte    = BTE_LINEAR;
    assign wshb_ifm.adr    = adr_q;
    assign wshb_ifm.dat_ms = dat_q;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer on a 4x2 framebuffer: a raster-order write model checked
// every cycle, plus directed stream scenarios (pattern scenario under FB_WRITER_PATTERN_EN).
module tb_fb_writer;

    localparam int HDISP = 4;
    localparam int VDISP = 2;
    localparam int TOTAL = HDISP * VDISP;
`ifdef FB_WRITER_PATTERN_EN
    localparam logic [31:0] BASE = 32'h100;
    localparam bit PATTERN = 1'b1;
`else
    localparam logic [31:0] BASE = 32'h0;
    localparam bit PATTERN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if wshb (.clk(clk), .rst(rst));

    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [31:0] pix_data  = 32'h0;
    logic        pix_sof   = 1'b0;
    logic        frame_done;
    logic        sof_err;

    fb_writer #(.HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE)) dut (
        .wshb_ifm   (wshb),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the framebuffer contract: expected writes in raster order.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] log_adr[64];
    logic [31:0] log_dat[64];
    int          wcount   = 0;
    int          fd_cnt   = 0;
    int          se_cnt   = 0;
    int          pos      = 0;
    int          run      = 0;
    int          last_run = 0;
    bit          armed = 0, busy = 0, in_frame = 0, fd_exp = 0, se_exp = 0;
    bit          prev_hold = 0, mon_stb = 0, mon_ack = 0;
    logic [31:0] prev_adr, prev_dat;

    int ack_delay = 1;
    bit late_ack  = 0;

    function automatic logic [31:0] pattern_pixel(input int p);
        int px = p % HDISP;
        int py = p / HDISP;
        logic [7:0] bx = 8'(px);
        logic [7:0] by = 8'(py);
        if (px % 16 == 0 || py % 16 == 0) return 32'h00FF_FFFF;
        return {8'h00, bx, by, 8'h00};
    endfunction

    // Compare process: outputs sampled on the falling edge, model advanced afterwards.
    always @(negedge clk) begin
        wr_t e;
        bit  cap;
        if (armed) begin
            check("pix_ready", pix_ready, PATTERN ? 1'b0 : !busy);
            check("stb", wshb.stb, busy);
            check("cyc", wshb.cyc, busy);
            check("we", wshb.we, busy);
            check("sel_cti_bte", {wshb.sel, wshb.cti, wshb.bte}, {4'hF, 3'b000, 2'b00});
            check("frame_done", frame_done, fd_exp);
            check("sof_err", sof_err, se_exp);
            if (prev_hold) begin
                check("hold_adr", wshb.adr, prev_adr);
                check("hold_dat", wshb.dat_ms, prev_dat);
            end
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (sof_err === 1'b1) se_cnt++;
        if (wshb.stb === 1'b1) run++;
        else if (run > 0) begin
            last_run = run;
            run      = 0;
        end
        fd_exp = 0;
        se_exp = 0;
        if (rst) begin
            armed     = 1;
            busy      = 0;
            in_frame  = 0;
            pos       = 0;
            prev_hold = 0;
            exp_q.delete();
        end else if (armed) begin
            cap       = PATTERN ? !busy : (pix_valid && pix_ready === 1'b1);
            prev_hold = (wshb.stb === 1'b1) && !wshb.ack;
            prev_adr  = wshb.adr;
            prev_dat  = wshb.dat_ms;
            if (wshb.stb === 1'b1 && wshb.ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", wshb.adr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_adr", wshb.adr, e.adr);
                    check("wr_dat", wshb.dat_ms, e.dat);
                    fd_exp = e.last;
                end
                if (wcount < 64) begin
                    log_adr[wcount] = wshb.adr;
                    log_dat[wcount] = wshb.dat_ms;
                end
                wcount++;
                busy = 0;
            end
            if (cap) begin
                if (!PATTERN && pix_sof) begin
                    if (in_frame) se_exp = 1;
                    in_frame = 1;
                    pos      = 0;
                end
                if (PATTERN || in_frame) begin
                    e.adr  = BASE + 32'(pos * 4);
                    e.dat  = PATTERN ? pattern_pixel(pos) : pix_data;
                    e.last = (pos == TOTAL - 1);
                    exp_q.push_back(e);
                    busy = 1;
                    pos++;
                    if (pos == TOTAL) begin
                        pos      = 0;
                        in_frame = 0;
                    end
                end
            end
        end
        mon_stb = (wshb.stb === 1'b1);
        mon_ack = wshb.ack;
    end

    // Slave responder: ack after ack_delay cycles of stb, or a forced stray ack.
    initial begin
        int cnt = 0;
        wshb.ack    = 1'b0;
        wshb.dat_sm = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (late_ack) begin
                wshb.ack = 1'b1;
                late_ack = 0;
                cnt      = 0;
            end else if (mon_stb && mon_ack) begin
                wshb.ack = 1'b0;
                cnt      = 0;
            end else if (mon_stb) begin
                cnt++;
                wshb.ack = (cnt >= ack_delay);
            end else begin
                wshb.ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    task automatic send_pixel(input logic [31:0] d, input logic s);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        do begin
            @(negedge clk);
            n++;
        end while (pix_ready !== 1'b1 && n < 50);
        check("send_accept", pix_ready, 1'b1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d writes expected completion", wcount);
        $fatal(1);
    end

`ifdef FB_WRITER_PATTERN_EN
    initial begin
        int n = 0;
        idle(3);
        rst = 1'b0;
        while (wcount < 17 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("pat_writes", wcount >= 17, 1'b1);
        check("pat_adr0", log_adr[0], 32'h100);
        check("pat_dat0", log_dat[0], 32'h00FF_FFFF);
        check("pat_dat5", log_dat[5], 32'h0001_0100);
        check("pat_dat7", log_dat[7], 32'h0003_0100);
        check("pat_adr7", log_adr[7], 32'h11C);
        check("pat_adr8", log_adr[8], 32'h100);
        check("pat_frames", fd_cnt, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`else
    initial begin
        int w0;
        int se0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", pix_ready, 1'b1);
        check("rst_stb", wshb.stb, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;

        // Scenario 1: one complete frame.
        for (int i = 0; i < TOTAL; i++) send_pixel(32'h10 + 32'(i), i == 0);
        drain();
        check("t1_adr0", log_adr[0], 32'h00);
        check("t1_adr7", log_adr[7], 32'h1C);
        check("t1_dat7", log_dat[7], 32'h17);
        check("t1_frame_done", fd_cnt, 1);
        check("t1_stb_run", last_run, 2);

        // Scenario 2: non-sof pixels while idle are dropped.
        w0 = wcount;
        send_pixel(32'hAA, 1'b0);
        send_pixel(32'hBB, 1'b0);
        idle(3);
        check("t2_no_write", wcount, w0);
        send_pixel(32'h20, 1'b1);
        drain();
        check("t2_adr", log_adr[w0], BASE);
        check("t2_dat", log_dat[w0], 32'h20);

        // Scenario 3: slow slave, rest of the frame.
        ack_delay = 5;
        for (int i = 1; i < TOTAL; i++) send_pixel(32'h20 + 32'(i), 1'b0);
        drain();
        check("t3_stb_run", last_run, 6);
        check("t3_adr_last", log_adr[w0 + 7], 32'h1C);
        check("t3_frame_done", fd_cnt, 2);
        ack_delay = 1;

        // Scenario 4: sof on the third pixel resynchronises the frame.
        w0  = wcount;
        se0 = se_cnt;
        send_pixel(32'h30, 1'b1);
        send_pixel(32'h31, 1'b0);
        send_pixel(32'h32, 1'b1);
        for (int i = 3; i < 10; i++) send_pixel(32'h30 + 32'(i), 1'b0);
        drain();
        check("t4_sof_err", se_cnt, se0 + 1);
        check("t4_resync_adr", log_adr[w0 + 2], 32'h00);
        check("t4_resync_dat", log_dat[w0 + 2], 32'h32);
        check("t4_next_adr", log_adr[w0 + 3], 32'h04);
        check("t4_frame_done", fd_cnt, 3);

        // Scenario 5: reset during a pending write, then a stray ack.
        ack_delay = 5;
        send_pixel(32'h40, 1'b1);
        check("t5_stb_before", wshb.stb, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_stb_dropped", wshb.stb, 1'b0);
        check("t5_cyc_dropped", wshb.cyc, 1'b0);
        late_ack = 1;
        idle(4);
        ack_delay = 1;
        w0 = wcount;
        send_pixel(32'h50, 1'b0);
        idle(3);
        check("t5_idle_drop", wcount, w0);
        for (int i = 0; i < TOTAL; i++) send_pixel(32'h60 + 32'(i), i == 0);
        drain();
        check("t5_restart_adr", log_adr[w0], 32'h00);
        check("t5_frame_done", fd_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`endif

endmodule
